// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the ADS bus arbiter family.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Owner index held in the split record when no split is pending.
  localparam logic [2:0] SP_NONE = 3'd0;

  // One-hot (up to 8 bits) to binary index; a zero input maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// Request/grant/split signal bundle between masters, slaves and the arbiter.
// Latency: none (wires only).
// Backpressure: slave readiness travels as sready/sreadysp; the arbiter holds grants.
interface bus_arbiter_n_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_SLAVES-1:0]  sready;
  logic                   sreadysp;
  logic                   ssplit;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_W-1:0]      msel;
  logic [NUM_MASTERS-1:0] msplit;
  logic                   split_grant;

  // Bus-side view: masters raise requests, slaves report ready/split.
  modport master (
    output breq, sready, sreadysp, ssplit,
    input  bgrant, msel, msplit, split_grant
  );

  // Arbiter view.
  modport slave (
    input  breq, sready, sreadysp, ssplit,
    output bgrant, msel, msplit, split_grant
  );
endinterface

// File: rtl/arb_rr_picker.sv
// Picks one requester: lowest index, or first at/after a rotating pointer.
// Latency: purely combinational.
// Backpressure: none; vld_o low when no request is set.
module arb_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter bit RR_EN       = 1'b0,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MSEL_W-1:0]      ptr_i,
  output logic                   vld_o,
  output logic [MSEL_W-1:0]      idx_o
);
  logic [MSEL_W-1:0]      base;
  logic [NUM_MASTERS-1:0] rot;
  logic [NUM_MASTERS-1:0] low;
  logic [2:0]             off;
  logic [MSEL_W:0]        sum;

  // Rotate so the pointer sits at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    base  = RR_EN ? ptr_i : '0;
    rot   = NUM_MASTERS'({req_i, req_i} >> base);
    low   = rot & (~rot + NUM_MASTERS'(1));
    off   = onehot_to_idx(8'(low));
    sum   = {1'b0, base} + (MSEL_W+1)'(off);
    if (sum >= (MSEL_W+1)'(NUM_MASTERS)) sum = sum - (MSEL_W+1)'(NUM_MASTERS);
    idx_o = sum[MSEL_W-1:0];
    vld_o = |req_i;
  end
endmodule

// File: rtl/bus_arbiter_n.sv
// N-master ADS bus arbiter, fixed-priority or round-robin, with one tracked split.
// Latency: request to grant 1 cycle from IDLE; release to IDLE 1 cycle after breq drops.
// Backpressure: grants wait for slave ready; GRANT_TIMEOUT_EN caps hold at MAX_HOLD cycles.
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter bit RR_EN       = 1'b0,
  parameter int MAX_HOLD    = 16,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_n_if.slave bus
);
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
    $error("NUM_MASTERS must be in 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  arb_state_e             state_q, state_d;
  logic [MSEL_W-1:0]      owner_q, owner_d;
  logic [MSEL_W-1:0]      sp_owner_q, sp_owner_d;
  logic [MSEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                   sp_valid_q, sp_valid_d;
  logic                   split_grant_q, split_grant_d;
  logic [NUM_MASTERS-1:0] msplit_q, msplit_d;

  logic                   rdy_ns, rdy_all;
  logic [NUM_MASTERS-1:0] owner_oh, sp_oh, pick_req;
  logic                   pick_vld;
  logic [MSEL_W-1:0]      pick_idx, pick_nxt;
  logic                   release_bus;
  logic                   hold_expired;

  assign rdy_ns   = &bus.sready;
  assign rdy_all  = rdy_ns & bus.sreadysp;
  assign owner_oh = NUM_MASTERS'(1) << owner_q;
  assign sp_oh    = NUM_MASTERS'(1) << sp_owner_q;
  // While the split slave is still busy its parked master cannot be re-picked.
  assign pick_req = bus.ssplit ? (bus.breq & ~sp_oh) : bus.breq;
  assign pick_nxt = (pick_idx == MSEL_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + MSEL_W'(1);

  arb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .RR_EN      (RR_EN),
    .MSEL_W     (MSEL_W)
  ) u_picker (
    .req_i(pick_req),
    .ptr_i(rr_ptr_q),
    .vld_o(pick_vld),
    .idx_o(pick_idx)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_frozen;

  // Resumed split owner finishing its transfer is never timed out.
  assign hold_frozen  = sp_valid_q && (owner_q == sp_owner_q);
  assign hold_expired = (state_q == BUSY) && (hold_q == HOLD_W'(MAX_HOLD - 1))
                        && |(bus.breq & ~owner_oh & ~msplit_q);

  // Count consecutive BUSY cycles, saturating at MAX_HOLD-1.
  always_comb begin
    hold_d = '0;
    if (state_q == BUSY && !release_bus) begin
      if (hold_frozen || hold_q == HOLD_W'(MAX_HOLD - 1)) hold_d = hold_q;
      else                                                 hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Next-state: grant selection in IDLE, split capture/release and hand-back in BUSY.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    sp_valid_d    = sp_valid_q;
    sp_owner_d    = sp_owner_q;
    msplit_d      = msplit_q;
    rr_ptr_d      = rr_ptr_q;
    split_grant_d = 1'b0;
    release_bus   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.ssplit && sp_valid_q) begin
          state_d = BUSY;
          owner_d = sp_owner_q;
        end else if (pick_vld && (bus.ssplit ? (sp_valid_q && rdy_ns) : rdy_all)) begin
          state_d  = BUSY;
          owner_d  = pick_idx;
          rr_ptr_d = pick_nxt;
        end
      end
      BUSY: begin
        if (!sp_valid_q && bus.ssplit) begin
          sp_valid_d = 1'b1;
          sp_owner_d = owner_q;
          msplit_d   = msplit_q | owner_oh;
        end else if (sp_valid_q && owner_q == sp_owner_q && !bus.ssplit) begin
          sp_valid_d    = 1'b0;
          msplit_d      = msplit_q & ~owner_oh;
          split_grant_d = 1'b1;
        end
        release_bus = !bus.breq[owner_q] || (!sp_valid_q && bus.ssplit) || hold_expired;
        if (release_bus) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and split-record registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      sp_valid_q    <= 1'b0;
      sp_owner_q    <= MSEL_W'(SP_NONE);
      rr_ptr_q      <= '0;
      msplit_q      <= '0;
      split_grant_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      sp_valid_q    <= sp_valid_d;
      sp_owner_q    <= sp_owner_d;
      rr_ptr_q      <= rr_ptr_d;
      msplit_q      <= msplit_d;
      split_grant_q <= split_grant_d;
    end
  end

  assign bus.bgrant      = (state_q == BUSY) ? owner_oh : '0;
  assign bus.msel        = (state_q == BUSY) ? owner_q  : '0;
  assign bus.msplit      = msplit_q;
  assign bus.split_grant = split_grant_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: fixed-priority and round-robin instances on shared stimulus.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercised through random sready/sreadysp/ssplit.
module tb_bus_arbiter_n;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] breq;
  logic [2:0] sready;
  logic       sreadysp;
  logic       ssplit;
  int         checks;
  int         failures;

  bus_arbiter_n_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) fp_if ();
  bus_arbiter_n_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) rr_if ();

  assign fp_if.breq = breq;  assign fp_if.sready = sready;
  assign fp_if.sreadysp = sreadysp;  assign fp_if.ssplit = ssplit;
  assign rr_if.breq = breq;  assign rr_if.sready = sready;
  assign rr_if.sreadysp = sreadysp;  assign rr_if.ssplit = ssplit;

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .RR_EN(1'b0), .MAX_HOLD(16), .MSEL_W(2))
    u_fp (.clk(clk), .rst(rst), .bus(fp_if));
  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .RR_EN(1'b1), .MAX_HOLD(4), .MSEL_W(2))
    u_rr (.clk(clk), .rst(rst), .bus(rr_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bus owner, split record and round-robin pointer as plain ints.
  typedef struct {
    bit busy; int owner; bit spv; int spo; int ptr; bit sg; int hold;
  } mst_t;

  function automatic int m_pick(bit [3:0] req, bit rr, int ptr);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = rr ? (ptr + k) % 4 : k;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic mst_t m_step(mst_t s, bit rr, int maxh, bit [3:0] rq, bit [2:0] sr,
                                  bit srsp, bit sp, bit r);
    mst_t n;
    bit   rdy_ns, rel;
    int   p;
    bit [3:0] others;
    n = s;
    n.sg = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    rdy_ns = (sr == 3'b111);
    if (!s.busy) begin
      n.hold = 0;
      if (!sp) begin
        if (s.spv) begin
          n.busy = 1'b1; n.owner = s.spo;
        end else if (rq != 0 && rdy_ns && srsp) begin
          p = m_pick(rq, rr, s.ptr);
          n.busy = 1'b1; n.owner = p; n.ptr = (p + 1) % 4;
        end
      end else if (s.spv && rdy_ns) begin
        p = m_pick(rq & ~(4'b0001 << s.spo), rr, s.ptr);
        if (p >= 0) begin
          n.busy = 1'b1; n.owner = p; n.ptr = (p + 1) % 4;
        end
      end
    end else begin
      rel = !rq[s.owner] || (!s.spv && sp);
      if (!s.spv && sp) begin
        n.spv = 1'b1; n.spo = s.owner;
      end else if (s.spv && s.owner == s.spo && !sp) begin
        n.spv = 1'b0; n.sg = 1'b1;
      end
      if (TO_EN) begin
        others = rq & ~(4'b0001 << s.owner) & (s.spv ? ~(4'b0001 << s.spo) : 4'b1111);
        if (s.hold == maxh - 1 && others != 0) rel = 1'b1;
      end
      if (rel) begin
        n.busy = 1'b0; n.hold = 0;
      end else if (!(s.spv && s.owner == s.spo) && s.hold < maxh - 1) begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] m_grant(mst_t s);
    return s.busy ? 4'(1 << s.owner) : 4'b0000;
  endfunction
  function automatic logic [1:0] m_msel(mst_t s);
    return s.busy ? 2'(s.owner) : 2'b00;
  endfunction
  function automatic logic [3:0] m_msplit(mst_t s);
    return s.spv ? 4'(1 << s.spo) : 4'b0000;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; breq = 4'b0000; ssplit = 1'b0; sready = 3'b111; sreadysp = 1'b1;
    clk1();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0000) begin failures++; $display("FAIL reset_bgrant got=%b exp=0000", fp_if.bgrant); end
    checks++; if (fp_if.msel !== 2'b00) begin failures++; $display("FAIL reset_msel got=%0d exp=0", fp_if.msel); end
    checks++; if (fp_if.msplit !== 4'b0000) begin failures++; $display("FAIL reset_msplit got=%b exp=0000", fp_if.msplit); end
    checks++; if (fp_if.split_grant !== 1'b0) begin failures++; $display("FAIL reset_split_grant got=%b exp=0", fp_if.split_grant); end
    checks++; if (rr_if.bgrant !== 4'b0000) begin failures++; $display("FAIL reset_rr_bgrant got=%b exp=0000", rr_if.bgrant); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    breq = 4'b1010;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0010) begin failures++; $display("FAIL fp_first_grant got=%b exp=0010", fp_if.bgrant); end
    checks++; if (fp_if.msel !== 2'd1) begin failures++; $display("FAIL fp_first_msel got=%0d exp=1", fp_if.msel); end
    breq = 4'b1000;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0000) begin failures++; $display("FAIL fp_release_idle got=%b exp=0000", fp_if.bgrant); end
    clk1();
    checks++; if (fp_if.bgrant !== 4'b1000) begin failures++; $display("FAIL fp_second_grant got=%b exp=1000", fp_if.bgrant); end
    checks++; if (fp_if.msel !== 2'd3) begin failures++; $display("FAIL fp_second_msel got=%0d exp=3", fp_if.msel); end
    breq = 4'b0000;
    clk1();
  endtask

  task automatic test_round_robin();
    do_reset();
    breq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_own;
      exp_own = k % 4;
      clk1();
      checks++; if (rr_if.bgrant !== 4'(1 << exp_own)) begin failures++; $display("FAIL rr_order_%0d got=%b exp=%b", k, rr_if.bgrant, 4'(1 << exp_own)); end
      clk1();
      clk1();
      breq[exp_own] = 1'b0;
      clk1();
      checks++; if (rr_if.bgrant !== 4'b0000) begin failures++; $display("FAIL rr_gap_%0d got=%b exp=0000", k, rr_if.bgrant); end
      breq = 4'b1111;
    end
    breq = 4'b0000;
    clk1();
  endtask

  task automatic test_split();
    do_reset();
    breq = 4'b0100;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0100) begin failures++; $display("FAIL split_m2_grant got=%b exp=0100", fp_if.bgrant); end
    ssplit = 1'b1;
    clk1();
    checks++; if (fp_if.msplit !== 4'b0100) begin failures++; $display("FAIL split_park got=%b exp=0100", fp_if.msplit); end
    checks++; if (fp_if.bgrant !== 4'b0000) begin failures++; $display("FAIL split_idle got=%b exp=0000", fp_if.bgrant); end
    breq = 4'b0101;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0001) begin failures++; $display("FAIL split_other_grant got=%b exp=0001", fp_if.bgrant); end
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0001) begin failures++; $display("FAIL split_ignore_second got=%b exp=0001", fp_if.bgrant); end
    breq = 4'b0100;
    clk1();
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0000) begin failures++; $display("FAIL split_parked_wait got=%b exp=0000", fp_if.bgrant); end
    ssplit = 1'b0;
    breq = 4'b0101;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0100) begin failures++; $display("FAIL split_resume got=%b exp=0100", fp_if.bgrant); end
    checks++; if (fp_if.split_grant !== 1'b0) begin failures++; $display("FAIL split_grant_early got=%b exp=0", fp_if.split_grant); end
    clk1();
    checks++; if (fp_if.split_grant !== 1'b1) begin failures++; $display("FAIL split_grant_pulse got=%b exp=1", fp_if.split_grant); end
    checks++; if (fp_if.msplit !== 4'b0000) begin failures++; $display("FAIL split_msplit_clear got=%b exp=0000", fp_if.msplit); end
    clk1();
    checks++; if (fp_if.split_grant !== 1'b0) begin failures++; $display("FAIL split_grant_width got=%b exp=0", fp_if.split_grant); end
    breq = 4'b0000;
    clk1();
  endtask

  task automatic test_reset_mid();
    do_reset();
    breq = 4'b0100;
    clk1();
    ssplit = 1'b1;
    clk1();
    breq = 4'b0101;
    clk1();
    rst = 1'b1;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b0000) begin failures++; $display("FAIL midrst_bgrant got=%b exp=0000", fp_if.bgrant); end
    checks++; if (fp_if.msplit !== 4'b0000) begin failures++; $display("FAIL midrst_msplit got=%b exp=0000", fp_if.msplit); end
    checks++; if (fp_if.msel !== 2'd0) begin failures++; $display("FAIL midrst_msel got=%0d exp=0", fp_if.msel); end
    rst = 1'b0; ssplit = 1'b0; breq = 4'b1000;
    clk1();
    checks++; if (fp_if.bgrant !== 4'b1000) begin failures++; $display("FAIL midrst_regrant got=%b exp=1000", fp_if.bgrant); end
    breq = 4'b0000;
    clk1();
  endtask

  task automatic test_timeout();
    do_reset();
    breq = 4'b0001;
    clk1();
    breq = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rr_if.bgrant !== 4'b0001) begin failures++; $display("FAIL timeout_hold_%0d got=%b exp=0001", k, rr_if.bgrant); end
      clk1();
    end
    checks++; if (rr_if.bgrant !== 4'b0000) begin failures++; $display("FAIL timeout_release got=%b exp=0000", rr_if.bgrant); end
    clk1();
    checks++; if (rr_if.bgrant !== 4'b0010) begin failures++; $display("FAIL timeout_next got=%b exp=0010", rr_if.bgrant); end
    breq = 4'b0000;
    clk1();
  endtask

  task automatic test_random();
    mst_t mf, mr;
    do_reset();
    mf = '{default: 0};
    mr = '{default: 0};
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) breq = 4'($urandom);
      sready   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      sreadysp = ($urandom_range(0, 7) != 0);
      ssplit   = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      clk1();
      mf = m_step(mf, 1'b0, 16, breq, sready, sreadysp, ssplit, rst);
      mr = m_step(mr, 1'b1, 4, breq, sready, sreadysp, ssplit, rst);
      checks++; if (fp_if.bgrant !== m_grant(mf)) begin failures++; $display("FAIL rand_fp_bgrant c=%0d got=%b exp=%b", c, fp_if.bgrant, m_grant(mf)); end
      checks++; if (fp_if.msel !== m_msel(mf)) begin failures++; $display("FAIL rand_fp_msel c=%0d got=%0d exp=%0d", c, fp_if.msel, m_msel(mf)); end
      checks++; if (fp_if.msplit !== m_msplit(mf)) begin failures++; $display("FAIL rand_fp_msplit c=%0d got=%b exp=%b", c, fp_if.msplit, m_msplit(mf)); end
      checks++; if (fp_if.split_grant !== mf.sg) begin failures++; $display("FAIL rand_fp_sg c=%0d got=%b exp=%b", c, fp_if.split_grant, mf.sg); end
      checks++; if (rr_if.bgrant !== m_grant(mr)) begin failures++; $display("FAIL rand_rr_bgrant c=%0d got=%b exp=%b", c, rr_if.bgrant, m_grant(mr)); end
      checks++; if (rr_if.msel !== m_msel(mr)) begin failures++; $display("FAIL rand_rr_msel c=%0d got=%0d exp=%0d", c, rr_if.msel, m_msel(mr)); end
      checks++; if (rr_if.msplit !== m_msplit(mr)) begin failures++; $display("FAIL rand_rr_msplit c=%0d got=%b exp=%b", c, rr_if.msplit, m_msplit(mr)); end
      checks++; if (rr_if.split_grant !== mr.sg) begin failures++; $display("FAIL rand_rr_sg c=%0d got=%b exp=%b", c, rr_if.split_grant, mr.sg); end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; breq = 4'b0000; sready = 3'b111; sreadysp = 1'b1; ssplit = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_split();
    test_reset_mid();
    if (TO_EN) test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
